park_gate_controller: RTL and testbench
=======================================

PARK_GATE_CONTROLLER -- requirements
Module: park_gate_controller

Interface
REQ-001 The block SHALL have exactly one parameter: GATE_CYCLES, default 4, the number of cycles a gate stays open per grant (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  1 = controller accepts new requests; 0 = new requests ignored.
REQ-005 entry_req  input  1  level request from the entry gate; held until entry_ack.
REQ-006 exit_req  input  1  level request from the exit gate; held until exit_ack or exit_err.
REQ-007 exit_space  input  3  space number being vacated; sampled with exit_req.
REQ-008 parking_capacity  output  8  occupancy map, bit n = 1 means space n is occupied.
REQ-009 park_number  output  3  space assigned by the last entry grant.
REQ-010 entry_ack / exit_ack  output  1 each  one-cycle grant pulses.
REQ-011 exit_err  output  1  one-cycle pulse when an exit names a free space.
REQ-012 entry_gate_open / exit_gate_open  output  1 each  gate actuator drives.
REQ-013 full / empty  output  1 each  map == 8'hFF / map == 8'h00.
REQ-014 free_count  output  4  number of zero bits in parking_capacity (0..8).

Function
REQ-015 FSM states SHALL be IDLE, ENTRY_OPEN and EXIT_OPEN; requests SHALL be evaluated only in IDLE.
REQ-016 In IDLE with enable=1 and exit_req=1, exit SHALL take priority over entry.
REQ-017 On an exit where parking_capacity[exit_space]=1: at the next edge clear that bit, pulse exit_ack, and enter EXIT_OPEN.
REQ-018 On an exit where parking_capacity[exit_space]=0: pulse exit_err for one cycle, leave the map unchanged, and remain in IDLE.
REQ-019 In IDLE, when there is no exit and entry_req=1 with full=0: allocate the highest-index free space (priority-encoder order, bit 7 first), set its bit, load park_number, pulse entry_ack, and enter ENTRY_OPEN.
REQ-020 An entry_req received while full=1 SHALL NOT be acknowledged, and the FSM SHALL remain in IDLE with the request pending.
REQ-021 All outputs SHALL be registered; ack and err pulses, map updates and gate_open SHALL all become visible in the cycle after the deciding edge.
REQ-022 The gate_open output SHALL be high for exactly GATE_CYCLES consecutive cycles starting with the ack cycle, after which the FSM returns to IDLE; total latency from request to ack is 1 cycle.
REQ-023 A request still high on the return to IDLE SHALL be treated as a new request (the requester must drop it after its ack).
REQ-024 Dropping enable during an open state SHALL NOT shorten the gate cycle.
REQ-025 When enable=0 in IDLE, no ack, err, map change or state change SHALL occur.
REQ-026 Entry and exit gates SHALL never be open in the same cycle.
REQ-027 full, empty and free_count SHALL be consistent with parking_capacity in every cycle.
REQ-028 park_number SHALL hold its value until the next entry grant.

Reset
REQ-029 reset=1 at a clock edge SHALL force IDLE, parking_capacity=8'h00, park_number=0, all acks, err and gate outputs 0, empty=1, full=0, free_count=8, and clear the gate timer.
REQ-030 A reset asserted mid-operation (in ENTRY_OPEN or EXIT_OPEN) SHALL close the gate in the next cycle and discard the grant in progress.

Verification
REQ-031 Two entries from empty: reset, then entry_req twice -> park_number=7 with map 8'h80, then park_number=6 with map 8'hC0; entry_gate_open high for 4 cycles each; free_count=6.
REQ-032 Exit then re-entry: map 8'hC0, exit_space=7 -> exit_ack, map 8'h40, exit_gate_open for 4 cycles; the next entry -> park_number=7, map 8'hC0.
REQ-033 Simultaneous requests while full: map 8'hFF, entry_req and exit_req (space 3) together -> exit served first, map 8'hF7; after 4 cycles the held entry is granted, park_number=3, map 8'hFF, full=1.
REQ-034 Invalid exit: map 8'h80, exit_space=2 -> one-cycle exit_err, no exit_ack, map stays 8'h80, gate stays closed.
REQ-035 Full and disabled cases: map 8'hFF with entry_req held 10 cycles -> no entry_ack; with enable=0 and entry_req=1 in IDLE -> no change.
REQ-036 Reset mid-grant: reset in the 2nd cycle of ENTRY_OPEN -> next cycle map=8'h00, entry_gate_open=0, FSM in IDLE.

Source files
------------

// File: rtl/park_gate_controller.sv
// Parking gate controller: tracks an 8-space occupancy map, grants entry and exit
// requests, and drives each gate actuator for GATE_CYCLES cycles per grant.
// Latency: one cycle from a sampled request to ack/err, map update and gate open.
// Backpressure: requests are level-held and served only in IDLE. An entry waits while the lot is full.
//
// Ports:
//   clk, reset                       - single clock, synchronous active-high reset
//   enable                           - 0 blocks evaluation of new requests in IDLE
//   entry_req                        - entry request level, held until entry_ack
//   exit_req, exit_space             - exit request level and the space being vacated
//   parking_capacity                 - occupancy map, bit n = space n occupied
//   park_number                      - space assigned by the most recent entry grant
//   entry_ack, exit_ack, exit_err    - one-cycle result pulses
//   entry_gate_open, exit_gate_open  - gate actuator drives
//   full, empty, free_count          - status derived from the occupancy map
module park_gate_controller #(
  parameter int unsigned GATE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [2:0] exit_space,
  output logic [7:0] parking_capacity,
  output logic [2:0] park_number,
  output logic       entry_ack,
  output logic       exit_ack,
  output logic       exit_err,
  output logic       entry_gate_open,
  output logic       exit_gate_open,
  output logic       full,
  output logic       empty,
  output logic [3:0] free_count
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ENTRY_OPEN = 2'd1,
    EXIT_OPEN  = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] gate_timer;

  logic       exit_hit;
  logic       do_exit;
  logic       do_err;
  logic       do_entry;
  logic [2:0] free_idx;
  logic [7:0] map_nxt;

  // Highest-index zero bit of the map; only meaningful when the map is not full.
  function automatic logic [2:0] highest_free(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] zero_count(input logic [7:0] m);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'd0, ~m[i]};
    end
    return cnt;
  endfunction

  // Decision logic for the IDLE state. Exit has priority over entry, so an
  // entry is only considered when no exit request is present.
  always_comb begin
    exit_hit = parking_capacity[exit_space];
    free_idx = highest_free(parking_capacity);
    do_exit  = (state == IDLE) && enable && exit_req && exit_hit;
    do_err   = (state == IDLE) && enable && exit_req && !exit_hit;
    do_entry = (state == IDLE) && enable && !exit_req && entry_req
               && (parking_capacity != 8'hFF);
    map_nxt  = parking_capacity;
    if (do_exit)  map_nxt[exit_space] = 1'b0;
    if (do_entry) map_nxt[free_idx]   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      gate_timer       <= 4'd0;
      parking_capacity <= 8'h00;
      park_number      <= 3'd0;
      entry_ack        <= 1'b0;
      exit_ack         <= 1'b0;
      exit_err         <= 1'b0;
      entry_gate_open  <= 1'b0;
      exit_gate_open   <= 1'b0;
      full             <= 1'b0;
      empty            <= 1'b1;
      free_count       <= 4'd8;
    end else begin
      entry_ack <= 1'b0;
      exit_ack  <= 1'b0;
      exit_err  <= 1'b0;

      // Status flags are registered from the next map so they always line up
      // with the registered parking_capacity.
      parking_capacity <= map_nxt;
      full             <= (map_nxt == 8'hFF);
      empty            <= (map_nxt == 8'h00);
      free_count       <= zero_count(map_nxt);

      case (state)
        IDLE: begin
          if (do_exit) begin
            exit_ack       <= 1'b1;
            exit_gate_open <= 1'b1;
            gate_timer     <= 4'(GATE_CYCLES - 1);
            state          <= EXIT_OPEN;
          end else if (do_err) begin
            exit_err <= 1'b1;
          end else if (do_entry) begin
            entry_ack       <= 1'b1;
            entry_gate_open <= 1'b1;
            park_number     <= free_idx;
            gate_timer      <= 4'(GATE_CYCLES - 1);
            state           <= ENTRY_OPEN;
          end
        end
        ENTRY_OPEN, EXIT_OPEN: begin
          // The timer holds the number of open cycles still to come after the
          // current one; enable is deliberately ignored here.
          if (gate_timer == 4'd0) begin
            entry_gate_open <= 1'b0;
            exit_gate_open  <= 1'b0;
            state           <= IDLE;
          end else begin
            gate_timer <= gate_timer - 4'd1;
          end
        end
        default: begin
          entry_gate_open <= 1'b0;
          exit_gate_open  <= 1'b0;
          state           <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_park_gate_controller.sv
// Directed bench for park_gate_controller with hand-computed expectations.
module tb_park_gate_controller;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       entry_req;
  logic       exit_req;
  logic [2:0] exit_space;
  logic [7:0] parking_capacity;
  logic [2:0] park_number;
  logic       entry_ack;
  logic       exit_ack;
  logic       exit_err;
  logic       entry_gate_open;
  logic       exit_gate_open;
  logic       full;
  logic       empty;
  logic [3:0] free_count;

  int total;
  int bad;

  park_gate_controller #(.GATE_CYCLES(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .entry_req        (entry_req),
    .exit_req         (exit_req),
    .exit_space       (exit_space),
    .parking_capacity (parking_capacity),
    .park_number      (park_number),
    .entry_ack        (entry_ack),
    .exit_ack         (exit_ack),
    .exit_err         (exit_err),
    .entry_gate_open  (entry_gate_open),
    .exit_gate_open   (exit_gate_open),
    .full             (full),
    .empty            (empty),
    .free_count       (free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count consecutive cycles the chosen gate is open, starting with the
  // current sampled cycle; leaves the bench in the first closed cycle.
  task automatic gate_len(input bit is_exit, output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!(is_exit ? exit_gate_open : entry_gate_open)) break;
      n++;
      tick();
    end
  endtask

  task automatic grant_entry();
    int n;
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    gate_len(1'b0, n);
  endtask

  task automatic grant_exit(input logic [2:0] sp);
    int n;
    exit_space = sp;
    exit_req   = 1'b1;
    tick();
    exit_req   = 1'b0;
    gate_len(1'b1, n);
  endtask

  initial begin
    int n;
    int acks;
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    enable     = 1'b1;
    entry_req  = 1'b0;
    exit_req   = 1'b0;
    exit_space = 3'd0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_map",   32'(parking_capacity), 32'h00);
    check("rst_empty", 32'(empty),            32'd1);
    check("rst_full",  32'(full),             32'd0);
    check("rst_free",  32'(free_count),       32'd8);
    check("rst_park",  32'(park_number),      32'd0);
    check("rst_gates", 32'({entry_gate_open, exit_gate_open, entry_ack, exit_ack, exit_err}), 32'd0);

    // Two entries from empty
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    check("e1_ack",  32'(entry_ack),        32'd1);
    check("e1_park", 32'(park_number),      32'd7);
    check("e1_map",  32'(parking_capacity), 32'h80);
    check("e1_gate", 32'(entry_gate_open),  32'd1);
    tick();
    check("e1_ack_pulse", 32'(entry_ack), 32'd0);
    gate_len(1'b0, n);
    check("e1_gate_len", 32'(n + 1), 32'd4);

    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    check("e2_park", 32'(park_number),      32'd6);
    check("e2_map",  32'(parking_capacity), 32'hC0);
    gate_len(1'b0, n);
    check("e2_gate_len", 32'(n),          32'd4);
    check("e2_free",     32'(free_count), 32'd6);

    // Exit of space 7 then re-entry
    exit_space = 3'd7;
    exit_req   = 1'b1;
    tick();
    exit_req = 1'b0;
    check("x7_ack",   32'(exit_ack),         32'd1);
    check("x7_map",   32'(parking_capacity), 32'h40);
    check("x7_egate", 32'(entry_gate_open),  32'd0);
    gate_len(1'b1, n);
    check("x7_gate_len", 32'(n), 32'd4);
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    check("re_park", 32'(park_number),      32'd7);
    check("re_map",  32'(parking_capacity), 32'hC0);
    gate_len(1'b0, n);

    // Fill the lot (spaces 5..0)
    for (int i = 0; i < 6; i++) grant_entry();
    check("fill_map",  32'(parking_capacity), 32'hFF);
    check("fill_full", 32'(full),             32'd1);
    check("fill_free", 32'(free_count),       32'd0);
    check("fill_park", 32'(park_number),      32'd0);

    // Simultaneous requests while full: exit wins, held entry follows
    entry_req  = 1'b1;
    exit_req   = 1'b1;
    exit_space = 3'd3;
    tick();
    exit_req = 1'b0;
    check("sim_xack", 32'(exit_ack),         32'd1);
    check("sim_eack", 32'(entry_ack),        32'd0);
    check("sim_map",  32'(parking_capacity), 32'hF7);
    gate_len(1'b1, n);
    check("sim_gate_len", 32'(n), 32'd4);
    tick();
    entry_req = 1'b0;
    check("sim_eack2", 32'(entry_ack),        32'd1);
    check("sim_park",  32'(park_number),      32'd3);
    check("sim_map2",  32'(parking_capacity), 32'hFF);
    check("sim_full",  32'(full),             32'd1);
    gate_len(1'b0, n);

    // Entry held 10 cycles while full
    entry_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (entry_ack || entry_gate_open) acks++;
    end
    entry_req = 1'b0;
    check("full_noack", 32'(acks),             32'd0);
    check("full_map",   32'(parking_capacity), 32'hFF);

    // Empty spaces 0..6 to reach map 8'h80
    for (int i = 0; i < 7; i++) grant_exit(3'(i));
    check("drain_map", 32'(parking_capacity), 32'h80);

    // Exit naming a free space
    exit_space = 3'd2;
    exit_req   = 1'b1;
    tick();
    exit_req = 1'b0;
    check("err_pulse", 32'(exit_err),         32'd1);
    check("err_noack", 32'(exit_ack),         32'd0);
    check("err_map",   32'(parking_capacity), 32'h80);
    check("err_gate",  32'(exit_gate_open),   32'd0);
    tick();
    check("err_once",  32'(exit_err),         32'd0);
    check("err_gate2", 32'(exit_gate_open),   32'd0);

    // Disabled in IDLE: requests ignored
    enable    = 1'b0;
    entry_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (entry_ack || entry_gate_open || exit_err) acks++;
    end
    check("dis_noack", 32'(acks),             32'd0);
    check("dis_map",   32'(parking_capacity), 32'h80);

    // Re-enable: pending entry granted; dropping enable keeps full gate length
    enable = 1'b1;
    tick();
    entry_req = 1'b0;
    enable    = 1'b0;
    check("en_park", 32'(park_number),      32'd6);
    check("en_map",  32'(parking_capacity), 32'hC0);
    gate_len(1'b0, n);
    check("en_gate_len", 32'(n), 32'd4);
    enable = 1'b1;

    // Reset in the 2nd cycle of ENTRY_OPEN
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    check("mr_park", 32'(park_number),      32'd5);
    check("mr_map",  32'(parking_capacity), 32'hE0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_map0",  32'(parking_capacity), 32'h00);
    check("mr_gate",  32'(entry_gate_open),  32'd0);
    check("mr_empty", 32'(empty),            32'd1);
    check("mr_free",  32'(free_count),       32'd8);
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    check("mr_idle_ack", 32'(entry_ack),   32'd1);
    check("mr_idle_pn",  32'(park_number), 32'd7);
    gate_len(1'b0, n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
